ymux_nto1_arb: RTL and testbench
================================

# ymux_nto1_arb

Parametrised, registered N-to-1 multiplexer for the datapath: the clocked successor to the 4-to-1 mux. It selects one of N WIDTH-bit input channels, either by an explicit select or by round-robin arbitration among valid channels. The winner is captured into a single-entry output register with a valid/ready handshake. It sits between multiple producers (register-file read ports, ALU result sources) and one consumer.

## Interface
- WIDTH, 32, bits per channel.
- N, 4, number of input channels (2..16, need not be a power of two).
- SELW, $clog2(N), select/index width (derived; do not override).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N  per-channel data valid.
- in_data  in  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- in_ready  out  N  one-hot-or-zero; channel i transfers when in_valid[i] & in_ready[i].
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used in fixed mode.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SELW  index of the channel that produced out_data.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.

## Operation
- Output slot state machine, 2 states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = EMPTY | (FULL & out_ready).
- Fixed mode: candidate = sel. Grant only if sel < N and in_valid[sel]. In_valid on other channels is ignored.
- Round-robin mode: candidate = first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1. No grant if in_valid == 0.
- in_ready[g] = load_en & grant_valid for the granted g. All other bits are 0. in_ready is combinational from in_valid, mode, sel, ptr, state and out_ready.
- On transfer: out_data <= in_data[g], out_sel <= g, state -> FULL.
- On pop without load: state -> EMPTY. out_data and out_sel hold their last value.
- Simultaneous pop and load: state stays FULL, new data loaded. Sustained throughput is 1 word/cycle.
- ptr (SELW bits) updates only on a round-robin transfer: ptr <= (g == N-1) ? 0 : g+1. Wrap is modulo N, not 2^SELW.
- Fixed-mode transfers do not move ptr. A mode change takes effect on the same cycle (purely combinational selection); ptr is retained across mode changes.
- sel >= N: no grant, all in_ready = 0, no error flag.
- While FULL & !out_ready: out_data, out_sel, out_valid are stable; all in_ready = 0.

## Timing
- Reset (async assert, sync-safe deassert): state = EMPTY, out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
- Reset mid-operation: any held word is discarded; first grant after reset uses ptr = 0.
- Latency: input transfer at edge k gives out_valid = 1 after edge k, visible in cycle k+1.
- No combinational path from in_data to out_data. There is a combinational path out_ready -> in_ready.
- Producers may not drop in_valid before their transfer. The block does not enforce this and the bench does not test it.

## Structure
- Package ymux_pkg: mode constants MODE_FIXED = 1'b0, MODE_RR = 1'b1; state enum ST_EMPTY, ST_FULL.
- Sub-module ymux_rr_pick (combinational). Inputs: req[N] and ptr. Outputs: gnt_idx[SELW] and gnt_valid. Implement via a doubled request vector and lowest-set-bit search, with the index reduced mod N.
- Top: picker, fixed/RR candidate mux, 2-state FSM, output register, ptr register.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0000. Assert rst_n mid-FULL -> out_valid drops immediately.
- Fixed mode: N = 4, sel = 2, in_valid = 1111, in_data = {D3,D2,D1,D0}, out_ready = 1 -> in_ready = 0100, next cycle out_data = D2, out_sel = 2. Repeat sel = 0..3 for 10 random vectors, with out_data checked against an expected value.
- Round-robin fairness: mode = 1, in_valid = 1111, out_ready = 1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3. With in_valid = 1010 -> 1,3,1,3.
- Backpressure: FULL with out_ready = 0 for 5 cycles -> out_data and out_sel constant, in_ready = 0000. Raise out_ready -> pop and load in the same cycle, out_valid stays 1.
- Non-power-of-two: N = 3, mode = 1, in_valid = 100 with ptr = 2 -> grant 2, ptr wraps to 0. Fixed mode with sel = 3 -> no grant.
- Mode switch: RR until ptr = 2, switch to fixed sel = 0 for 2 transfers, then back to RR with in_valid = 1111 -> next grant is 2.

Source files
------------

// File: rtl/ymux_pkg.sv
// ymux_pkg: shared mode constants and output-slot state encoding for the N-to-1 arbiter
package ymux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
endpackage

// File: rtl/ymux_rr_pick.sv
// ymux_rr_pick: combinational round-robin picker, first set req at or after ptr (mod N)
//   req       in  N     request vector
//   ptr       in  SELW  highest-priority index
//   gnt_idx   out SELW  winning index (valid only with gnt_valid)
//   gnt_valid out 1     any request present
module ymux_rr_pick #(
  parameter int N = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);
  logic [2*N-1:0] dbl;
  logic [SELW:0]  pos;
  always_comb begin
    dbl = {req, req};
    pos = '0;
    gnt_valid = 1'b0;
    // descending scan so the last hit, i.e. the lowest index in the window, wins
    for (int j = 2*N-1; j >= 0; j--)
      if (dbl[j] && j >= int'(ptr) && j < int'(ptr) + N) begin
        pos = (SELW+1)'(j);
        gnt_valid = 1'b1;
      end
    gnt_idx = (pos >= (SELW+1)'(N)) ? SELW'(pos - (SELW+1)'(N)) : SELW'(pos);
  end
endmodule

// File: rtl/ymux_nto1_arb.sv
// ymux_nto1_arb: registered N-to-1 mux with fixed-select or round-robin arbitration
//   in_valid/in_data/in_ready  N producer channels (channel i at in_data[i*WIDTH +: WIDTH])
//   mode                       0 fixed select via sel, 1 round-robin
//   out_valid/out_data/out_sel single-entry output register, out_sel names the source
//   out_ready                  consumer accept
module ymux_nto1_arb
  import ymux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);
  localparam int P = 2**SELW;
  state_t            state, state_nxt;
  logic [SELW-1:0]   ptr, rr_idx, cand;
  logic              rr_v, gv, load_en, xfer, pop;
  logic [P-1:0]      vpad;
  logic [WIDTH-1:0]  din;
  ymux_rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .req(in_valid), .ptr(ptr), .gnt_idx(rr_idx), .gnt_valid(rr_v)
  );
  // zero padding makes any sel >= N read as "not valid"
  assign vpad = P'(in_valid);
  assign cand = (mode == MODE_RR) ? rr_idx : sel;
  assign gv = (mode == MODE_RR) ? rr_v : vpad[sel];
  assign load_en = (state == ST_EMPTY) || out_ready;
  assign pop = (state == ST_FULL) && out_ready;
  // rst_n gating keeps in_ready quiet while reset is held
  assign xfer = rst_n && load_en && gv;
  assign in_ready = xfer ? (N'(1) << cand) : '0;
  assign out_valid = (state == ST_FULL);
  always_comb begin
    din = '0;
    for (int i = 0; i < N; i++)
      if (cand == SELW'(i)) din = in_data[i*WIDTH +: WIDTH];
  end
  always_comb state_nxt = xfer ? ST_FULL : (pop ? ST_EMPTY : state);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_EMPTY;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        out_data <= din;
        out_sel <= cand;
        if (mode == MODE_RR) ptr <= (cand == SELW'(N-1)) ? '0 : cand + 1'b1;
      end
    end
endmodule

// File: tb/tb_ymux_nto1_arb.sv
// tb_ymux_nto1_arb: randomized + directed check of ymux_nto1_arb (N=4 and N=3) against a behavioural model
module tb_ymux_nto1_arb;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] v4, rdy4;
  logic [4*W-1:0] d4;
  logic m4, ov4, or4;
  logic [1:0] s4, os4;
  logic [W-1:0] od4;
  logic [2:0] v3, rdy3;
  logic [3*W-1:0] d3;
  logic m3, ov3, or3;
  logic [1:0] s3, os3;
  logic [W-1:0] od3;
  ymux_nto1_arb #(.WIDTH(W), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .mode(m4), .sel(s4), .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(or4)
  );
  ymux_nto1_arb #(.WIDTH(W), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .mode(m3), .sel(s3), .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(or3)
  );
  int n_cmp = 0, n_bad = 0;
  bit mv[2];
  logic [W-1:0] md[2];
  int ms[2], mp[2];
  logic [W-1:0] d2;
  function automatic int pick(int n, int v, bit rr, int s, int p);
    if (!rr) return (s < n && v[s]) ? s : -1;
    for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction
  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic rnd();
    v4 = 4'($urandom); m4 = 1'($urandom); s4 = 2'($urandom); or4 = 1'($urandom);
    v3 = 3'($urandom); m3 = 1'($urandom); s3 = 2'($urandom); or3 = 1'($urandom);
    for (int i = 0; i < 4; i++) d4[i*W +: W] = $urandom;
    for (int i = 0; i < 3; i++) d3[i*W +: W] = $urandom;
  endtask
  task automatic cyc();
    int g[2];
    bit ld[2], rr[2], ordy[2];
    logic [W-1:0] dat[2];
    #1;
    for (int d = 0; d < 2; d++) begin
      int n = d ? 3 : 4;
      int v = d ? int'(v3) : int'(v4);
      int s = d ? int'(s3) : int'(s4);
      rr[d] = d ? m3 : m4;
      ordy[d] = d ? or3 : or4;
      g[d] = pick(n, v, rr[d], s, mp[d]);
      ld[d] = rst_n && (!mv[d] || ordy[d]);
      dat[d] = '0;
      if (g[d] >= 0) dat[d] = d ? d3[g[d]*W +: W] : d4[g[d]*W +: W];
      chk(d ? "in_ready3" : "in_ready4", d ? W'(rdy3) : W'(rdy4),
          (ld[d] && g[d] >= 0) ? W'(1 << g[d]) : '0);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (ld[d] && g[d] >= 0) begin
        mv[d] = 1'b1;
        md[d] = dat[d];
        ms[d] = g[d];
        if (rr[d]) mp[d] = (g[d] + 1) % (d ? 3 : 4);
      end else if (mv[d] && ordy[d]) mv[d] = 1'b0;
    end
    #1;
    chk("out_valid4", W'(ov4), W'(mv[0]));
    chk("out_data4", od4, md[0]);
    chk("out_sel4", W'(os4), W'(ms[0]));
    chk("out_valid3", W'(ov3), W'(mv[1]));
    chk("out_data3", od3, md[1]);
    chk("out_sel3", W'(os3), W'(ms[1]));
  endtask
  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      rnd();
      #2;
      chk("rst_valid4", W'(ov4), '0); chk("rst_data4", od4, '0);
      chk("rst_sel4", W'(os4), '0); chk("rst_ready4", W'(rdy4), '0);
      chk("rst_valid3", W'(ov3), '0); chk("rst_data3", od3, '0);
      chk("rst_sel3", W'(os3), '0); chk("rst_ready3", W'(rdy3), '0);
      @(posedge clk);
    end
    for (int d = 0; d < 2; d++) begin mv[d] = 1'b0; md[d] = '0; ms[d] = 0; mp[d] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    v4 = '0; d4 = '0; m4 = 1'b0; s4 = '0; or4 = 1'b0;
    v3 = '0; d3 = '0; m3 = 1'b0; s3 = '0; or3 = 1'b0;
    do_reset(3);
    v4 = '0; v3 = '0; or4 = 1'b1; or3 = 1'b1; m3 = 1'b1;
    v3 = 3'b010; cyc(); chk("n3_grant1", W'(os3), 1);
    v3 = 3'b100; cyc(); chk("n3_grant2", W'(os3), 2);
    v3 = 3'b111; cyc(); chk("n3_wrap0", W'(os3), 0);
    m3 = 1'b0; s3 = 2'd3; #1; chk("n3_sel3_noready", W'(rdy3), '0); cyc();
    v3 = '0;
    m4 = 1'b0; s4 = 2'd2; v4 = 4'b1111;
    for (int i = 0; i < 4; i++) d4[i*W +: W] = $urandom;
    d2 = d4[2*W +: W];
    #1; chk("fix_ready_0100", W'(rdy4), W'(4'b0100));
    cyc(); chk("fix_data_d2", od4, d2); chk("fix_sel_2", W'(os4), 2);
    for (int i = 0; i < 10; i++) begin
      rnd(); v3 = '0; m4 = 1'b0; s4 = 2'(i % 4); or4 = 1'b1;
      cyc();
    end
    m4 = 1'b1; v4 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) d4[c*W +: W] = $urandom;
      cyc(); chk("rr_1111", W'(os4), W'(i % 4));
    end
    v4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("rr_1010", W'(os4), (i % 2) ? 3 : 1);
    end
    v4 = 4'b1111; or4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 4; c++) d4[c*W +: W] = $urandom;
      #1; chk("bp_ready", W'(rdy4), '0);
      cyc(); chk("bp_sel", W'(os4), 3); chk("bp_valid", W'(ov4), 1);
    end
    or4 = 1'b1; cyc(); chk("bp_release_valid", W'(ov4), 1); chk("bp_release_sel", W'(os4), 0);
    cyc(); chk("ms_rr1", W'(os4), 1);
    m4 = 1'b0; s4 = 2'd0;
    cyc(); chk("ms_fix0a", W'(os4), 0);
    cyc(); chk("ms_fix0b", W'(os4), 0);
    m4 = 1'b1; cyc(); chk("ms_rr_resume2", W'(os4), 2);
    #2; rst_n = 1'b0; #1;
    chk("async_rst_valid4", W'(ov4), '0);
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      rnd();
      cyc();
      if ($urandom_range(0, 49) == 0 && ov4) begin
        #2; rst_n = 1'b0; #1;
        chk("async_rst_rand", W'(ov4), '0);
        do_reset(2);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
